wbck_arb: RTL

Writeback arbiter feeding the integer register file's single write port. Merges results from the single-cycle ALU path and the long-latency path (LSU / mul-div) into one `wbck_dest_wen`/`wbck_dest_idx`/`wbck_dest_dat` triple per cycle. Long-path results pass through a small FIFO so a multi-cycle unit can retire while the ALU holds the port. Round-robin arbitration under contention prevents either source from starving.

---
 rtl/cirno_core_pkg.sv | 22 ++
 rtl/wbck_longp_fifo.sv | 70 +++++++
 rtl/wbck_arb.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cirno_core_pkg.sv
// cirno_core_pkg -- shared core definitions for the writeback path.
//
// Contents:
//   XLEN, RFIDX_W   : data width and register-index width
//   longp_entry_t   : one buffered long-path result {rdidx, wdat}
//   wbck_prio_e     : which writeback source wins the next contended cycle
package cirno_core_pkg;

  localparam int XLEN    = 32;
  localparam int RFIDX_W = 5;

  typedef struct packed {
    logic [RFIDX_W-1:0] rdidx;
    logic [XLEN-1:0]    wdat;
  } longp_entry_t;

  typedef enum logic {
    PRIO_LONGP = 1'b0,
    PRIO_ALU   = 1'b1
  } wbck_prio_e;

endpackage

// File: rtl/wbck_longp_fifo.sv
// wbck_longp_fifo -- synchronous FIFO buffering long-path writeback results.
//
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (pointers only)
//   wr_en_i      : enqueue wr_data_i (caller guarantees !full_o)
//   wr_data_i    : entry to enqueue
//   rd_en_i      : dequeue head (caller guarantees !empty_o)
//   rd_data_o    : current head entry
//   full_o       : no free entries
//   empty_o      : no valid entries
module wbck_longp_fifo
  import cirno_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en_i,
  input  longp_entry_t wr_data_i,
  input  logic         rd_en_i,
  output longp_entry_t rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  longp_entry_t mem_q [DEPTH];

  logic do_wr;
  logic do_rd;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);

  assign do_wr = wr_en_i & ~full_o;
  assign do_rd = rd_en_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + 1'b1;
    if (do_rd) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset: an entry is only observable once the write
  // pointer has passed it.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/wbck_arb.sv
// wbck_arb -- writeback arbiter for the integer register file write port.
//
// Merges the zero-latency ALU result with buffered long-path results
// (LSU / mul-div). Long-path results always go through the FIFO (no bypass).
// Under contention a round-robin prio flop alternates the winner.
//
// Optional feature: define CIRNO_WBCK_STALL_CNT_EN to add the
// wbck_alu_stall_cnt output (saturating count of ALU-valid-but-not-granted
// cycles).
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   alu_wbck_valid/ready             : ALU result handshake
//   alu_wbck_rdwen/rdidx/wdat        : ALU write enable, index, data
//   longp_wbck_valid/ready           : long-path result handshake (enqueue)
//   longp_wbck_rdidx/wdat            : long-path index, data
//   wbck_dest_wen/idx/dat            : register-file write port
//   wbck_alu_stall_cnt               : ALU stall counter (optional)
module wbck_arb
  import cirno_core_pkg::*;
#(
  parameter int LONGP_FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_wbck_valid,
  output logic               alu_wbck_ready,
  input  logic               alu_wbck_rdwen,
  input  logic [RFIDX_W-1:0] alu_wbck_rdidx,
  input  logic [XLEN-1:0]    alu_wbck_wdat,
  input  logic               longp_wbck_valid,
  output logic               longp_wbck_ready,
  input  logic [RFIDX_W-1:0] longp_wbck_rdidx,
  input  logic [XLEN-1:0]    longp_wbck_wdat,
  output logic               wbck_dest_wen,
  output logic [RFIDX_W-1:0] wbck_dest_idx,
  output logic [XLEN-1:0]    wbck_dest_dat
`ifdef CIRNO_WBCK_STALL_CNT_EN
  ,
  output logic [31:0]        wbck_alu_stall_cnt
`endif
);

  longp_entry_t fifo_wr_data;
  longp_entry_t fifo_head;
  logic         fifo_full;
  logic         fifo_empty;

  wbck_prio_e   prio_q, prio_d;

  logic cand_f;
  logic cand_a;
  logic contend;
  logic grant_f;
  logic grant_a;
  logic longp_push;

  assign fifo_wr_data.rdidx = longp_wbck_rdidx;
  assign fifo_wr_data.wdat  = longp_wbck_wdat;

  wbck_longp_fifo #(
    .DEPTH (LONGP_FIFO_DEPTH)
  ) u_longp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (longp_push),
    .wr_data_i (fifo_wr_data),
    .rd_en_i   (grant_f),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Readies and grants are gated by rst_n so nothing handshakes or writes
  // while reset is asserted, independent of input activity.
  assign longp_wbck_ready = rst_n & ~fifo_full;
  assign longp_push       = longp_wbck_valid & longp_wbck_ready;

  assign cand_f  = ~fifo_empty;
  assign cand_a  = alu_wbck_valid;
  assign contend = cand_f & cand_a;

  assign grant_f = rst_n & cand_f & (~cand_a | (prio_q == PRIO_LONGP));
  assign grant_a = rst_n & cand_a & ~grant_f;

  assign alu_wbck_ready = grant_a;

  // Round robin: on a contended cycle the winner is demoted.
  always_comb begin
    prio_d = prio_q;
    if (contend) prio_d = grant_f ? PRIO_ALU : PRIO_LONGP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= PRIO_LONGP;
    else        prio_q <= prio_d;
  end

  // With no grant idx/dat follow the ALU inputs; wen stays low.
  // Long-path entries always write unless targeting x0.
  always_comb begin
    wbck_dest_idx = alu_wbck_rdidx;
    wbck_dest_dat = alu_wbck_wdat;
    wbck_dest_wen = grant_a & alu_wbck_rdwen & (alu_wbck_rdidx != '0);
    if (grant_f) begin
      wbck_dest_idx = fifo_head.rdidx;
      wbck_dest_dat = fifo_head.wdat;
      wbck_dest_wen = (fifo_head.rdidx != '0);
    end
  end

`ifdef CIRNO_WBCK_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (alu_wbck_valid && !alu_wbck_ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign wbck_alu_stall_cnt = stall_cnt_q;
`else
  // Stall counter not built in this configuration.
`endif

endmodule
